// File: rtl/fetch_seq.sv
// ---------------------------------------------------------------------------
// fetch_seq -- instruction-fetch sequencer for the single-issue RISC-V core.
//
// Owns the program counter and drives a variable-latency instruction memory
// through a req/gnt + rvalid handshake with a single request outstanding.
// One instruction is presented to decode at a time. Execute-stage redirects
// preempt everything else, stale in-flight fetches are killed, and a missing
// response raises a sticky timeout flag before the fetch is reissued.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous, active-low reset
//   imem_req         out  fetch request valid (only in the REQ state)
//   imem_addr        out  fetch address, always the registered pc
//   imem_gnt         in   memory accepted the request this cycle
//   imem_rvalid      in   read data valid, one per granted request
//   imem_rdata       in   read data
//   stall            in   decode cannot accept this cycle
//   redirect         in   control-flow change taken
//   redirect_target  in   new pc, bits [1:0] forced to zero
//   instr            out  instruction handed to decode
//   instr_pc         out  address of instr
//   instr_valid      out  instr / instr_pc are valid
//   fetch_err        out  sticky memory-timeout flag
//   perf_fetched     out  delivered-instruction counter
//   perf_killed      out  discarded-response counter
//
// Build option:
//   FETCH_SEQ_PERF_EN  when defined, perf_fetched / perf_killed are 32-bit
//                      wrapping counters; otherwise both ports are tied to 0
//                      and no counter flops exist.
// ---------------------------------------------------------------------------
module fetch_seq #(
    parameter int unsigned          PC_WIDTH       = 32,
    parameter int unsigned          INSTR_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned          TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   fetch_err,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_killed
);

    localparam int unsigned        CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = ~PC_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic                     kill_q, kill_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0]      instr_pc_q, instr_pc_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     fetch_err_q, fetch_err_d;
    logic [PC_WIDTH-1:0]      target_aligned;

    // Masking rather than slicing keeps every target bit in use.
    assign target_aligned = redirect_target & ALIGN_MASK;

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            kill_q        <= 1'b0;
            cnt_q         <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = target_aligned;
                end
                state_d = REQ;
            end

            // Any rvalid seen here belongs to an abandoned request and is
            // ignored. A fresh grant starts a clean transaction unless a
            // redirect arrives in the same cycle, in which case the
            // response for the old pc must be thrown away.
            REQ: begin
                if (redirect) begin
                    pc_d = target_aligned;
                end
                if (imem_gnt) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    kill_d  = redirect;
                end
            end

            // The counter saturates so that redirects arriving right at the
            // timeout boundary cannot make it wrap and hide the timeout.
            WAIT: begin
                if (cnt_q < TIMEOUT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                        if (redirect) begin
                            pc_d = target_aligned;
                        end
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + PC_STEP;
                        state_d       = HOLD;
                    end
                end else if (redirect) begin
                    pc_d   = target_aligned;
                    kill_d = 1'b1;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    fetch_err_d = 1'b1;
                    kill_d      = 1'b1;
                    state_d     = REQ;
                end
            end

            HOLD: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = target_aligned;
                    state_d       = REQ;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_killed_q;
    logic        fetch_event;
    logic        kill_event;

    assign fetch_event = (state_q == WAIT) && imem_rvalid && !kill_q && !redirect;
    assign kill_event  = (state_q == WAIT) && imem_rvalid && (kill_q || redirect);

    // Free-running counters; wrap-around at 2^32 is intended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_killed_q  <= '0;
        end else begin
            if (fetch_event) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (kill_event) begin
                perf_killed_q <= perf_killed_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_killed  = perf_killed_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_killed  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_fetch_seq -- self-checking bench for fetch_seq.
//
// A behavioural instruction memory grants whenever nothing is outstanding
// and answers after a programmable delay. Expected grant addresses and
// expected decode handoffs are queued up front with hand-computed values;
// the memory process checks grant addresses and a monitor checks every
// handoff (instr_valid && !stall) against the queues. The directed
// sequence also checks the stall hold, redirect kills, the timeout and an
// asynchronous reset in the middle of a fetch.
// ---------------------------------------------------------------------------
module tb_fetch_seq;

    localparam int PW = 32;
    localparam int IW = 32;

`ifdef FETCH_SEQ_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } expT;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          stall;
    logic          redirect;
    logic [PW-1:0] redirect_target;
    logic [IW-1:0] instr;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          fetch_err;
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_killed;

    int          checkCount = 0;
    int          errorCount = 0;
    expT         expQ[$];
    logic [31:0] addrQ[$];
    bit          memEnable = 1'b1;
    int          respDelay = 1;
    int          pendCnt   = 0;
    logic [31:0] pendAddr  = '0;

    fetch_seq #(
        .PC_WIDTH       (PW),
        .INSTR_WIDTH    (IW),
        .RESET_VECTOR   (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .fetch_err       (fetch_err),
        .perf_fetched    (perf_fetched),
        .perf_killed     (perf_killed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: memWord = 32'h0000_0013;
            32'h0000_0004: memWord = 32'h0050_0093;
            32'h0000_0008: memWord = 32'h00a0_0113;
            32'h0000_000C: memWord = 32'h00c0_0193;
            32'h0000_0040: memWord = 32'h0400_0293;
            32'h0000_0044: memWord = 32'h0010_8093;
            32'h0000_0100: memWord = 32'h1000_0213;
            32'h0000_0104: memWord = 32'h0020_8113;
            default:       memWord = 32'hffff_ffff;
        endcase
    endfunction

    // Memory model: drives gnt/rvalid at the falling edge so they are
    // stable at the next rising edge. Reset drops any pending response.
    initial begin
        logic [31:0] expAddr;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (!rst) begin
                pendCnt = 0;
            end else begin
                if (pendCnt > 0) begin
                    pendCnt--;
                    if (pendCnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memWord(pendAddr);
                    end
                end
                if (imem_req && memEnable && pendCnt == 0) begin
                    imem_gnt = 1'b1;
                    pendAddr = imem_addr;
                    pendCnt  = respDelay;
                    if (addrQ.size() == 0) begin
                        checkCount++;
                        errorCount++;
                        $display("[TB] FAIL grant_addr: actual=%0h required=none", imem_addr);
                    end else begin
                        expAddr = addrQ.pop_front();
                        checkOutput("grant_addr", {32'h0, imem_addr}, {32'h0, expAddr});
                    end
                end
            end
        end
    end

    // Monitor: handoffs are checked against the expected queue, and the
    // delivered counter is checked on every rising edge of instr_valid.
    initial begin
        bit  prevValid;
        int  fetchedCnt;
        expT e;
        prevValid  = 1'b0;
        fetchedCnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevValid  = 1'b0;
                fetchedCnt = 0;
            end else begin
                if (instr_valid && !prevValid) begin
                    fetchedCnt++;
                    checkOutput("perf_fetched", {32'h0, perf_fetched},
                                PERF_ON ? 64'(fetchedCnt) : 64'h0);
                end
                if (instr_valid && !stall) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        errorCount++;
                        $display("[TB] FAIL handoff: actual=%0h required=none", {instr_pc, instr});
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("handoff", {instr_pc, instr}, {e.pc, e.word});
                    end
                end
                prevValid = instr_valid;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"},       {63'h0, imem_req},    64'h0);
        checkOutput({tag, "_addr"},      {32'h0, imem_addr},   64'h0);
        checkOutput({tag, "_valid"},     {63'h0, instr_valid}, 64'h0);
        checkOutput({tag, "_instr"},     {32'h0, instr},       64'h0);
        checkOutput({tag, "_instr_pc"},  {32'h0, instr_pc},    64'h0);
        checkOutput({tag, "_fetch_err"}, {63'h0, fetch_err},   64'h0);
        checkOutput({tag, "_perf_f"},    {32'h0, perf_fetched}, 64'h0);
        checkOutput({tag, "_perf_k"},    {32'h0, perf_killed},  64'h0);
    endtask

    task automatic applyStimulus();
        int n;
        rst             = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;

        foreach (addrQ[i]) addrQ.delete(i);
        addrQ = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h40, 32'h44,
                  32'hC, 32'hC, 32'h10, 32'h0};
        expQ.push_back('{pc: 32'h0,   word: 32'h0000_0013});
        expQ.push_back('{pc: 32'h4,   word: 32'h0050_0093});
        expQ.push_back('{pc: 32'h100, word: 32'h1000_0213});
        expQ.push_back('{pc: 32'h40,  word: 32'h0400_0293});
        expQ.push_back('{pc: 32'hC,   word: 32'h00c0_0193});
        expQ.push_back('{pc: 32'h0,   word: 32'h0000_0013});

        tick();
        tick();
        checkResetValues("reset");

        // Release; one IDLE cycle, then back-to-back REQ/WAIT/HOLD.
        rst = 1'b1;
        tick();
        checkOutput("w1_req",   {63'h0, imem_req},    64'h1);
        checkOutput("w1_addr",  {32'h0, imem_addr},   64'h0);
        checkOutput("w1_valid", {63'h0, instr_valid}, 64'h0);
        tick();
        checkOutput("w2_req",   {63'h0, imem_req},    64'h0);
        checkOutput("w2_valid", {63'h0, instr_valid}, 64'h0);
        tick();
        checkOutput("w3_valid", {63'h0, instr_valid}, 64'h1);
        tick();
        checkOutput("w4_req",   {63'h0, imem_req},    64'h1);
        checkOutput("w4_addr",  {32'h0, imem_addr},   64'h4);
        stall = 1'b1;
        tick();
        tick();

        // Decode stalls for five cycles on the instruction at 0x4.
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", {63'h0, instr_valid},  64'h1);
            checkOutput("stall_instr", {instr_pc, instr},     {32'h4, 32'h0050_0093});
            checkOutput("stall_req",   {63'h0, imem_req},     64'h0);
            tick();
        end
        stall     = 1'b0;
        respDelay = 3;
        tick();
        checkOutput("after_stall_addr", {32'h0, imem_addr}, 64'h8);
        checkOutput("after_stall_req",  {63'h0, imem_req},  64'h1);

        // Redirect while the fetch of 0x8 is outstanding.
        tick();
        respDelay       = 1;
        redirect        = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect        = 1'b0;
        redirect_target = 32'hdead_beef;
        checkOutput("kill_wait_req", {63'h0, imem_req}, 64'h0);
        tick();
        tick();
        checkOutput("redir_req",  {63'h0, imem_req},   64'h1);
        checkOutput("redir_addr", {32'h0, imem_addr},  64'h100);
        checkOutput("perf_killed_1", {32'h0, perf_killed}, PERF_ON ? 64'h1 : 64'h0);
        tick();
        tick();
        checkOutput("hold_100_valid", {63'h0, instr_valid}, 64'h1);
        tick();
        tick();
        stall = 1'b1;
        tick();

        // Redirect in HOLD beats the stall.
        checkOutput("hold_104", {instr_pc, instr}, {32'h104, 32'h0020_8113});
        redirect        = 1'b1;
        redirect_target = 32'h40;
        tick();
        checkOutput("hold_redir_valid", {63'h0, instr_valid}, 64'h0);
        checkOutput("hold_redir_req",   {63'h0, imem_req},    64'h1);
        checkOutput("hold_redir_addr",  {32'h0, imem_addr},   64'h40);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        tick();
        tick();

        // Redirect in the same cycle as the grant of 0x44.
        checkOutput("req_44_addr", {32'h0, imem_addr}, 64'h44);
        redirect        = 1'b1;
        redirect_target = 32'hC;
        tick();
        redirect  = 1'b0;
        respDelay = 20;
        checkOutput("gnt_redir_req", {63'h0, imem_req}, 64'h0);
        tick();
        checkOutput("req_C_addr",    {32'h0, imem_addr},   64'hC);
        checkOutput("perf_killed_2", {32'h0, perf_killed}, PERF_ON ? 64'h2 : 64'h0);
        tick();
        respDelay = 1;

        // No response for 0xC: timeout after sixteen WAIT cycles.
        repeat (15) tick();
        checkOutput("pre_timeout_err", {63'h0, fetch_err}, 64'h0);
        tick();
        checkOutput("timeout_err",  {63'h0, fetch_err},   64'h1);
        checkOutput("timeout_req",  {63'h0, imem_req},    64'h1);
        checkOutput("timeout_addr", {32'h0, imem_addr},   64'hC);
        checkOutput("timeout_perf_k", {32'h0, perf_killed}, PERF_ON ? 64'h2 : 64'h0);
        tick();
        tick();
        tick();
        tick();
        respDelay = 5;
        tick();
        checkOutput("sticky_err", {63'h0, fetch_err}, 64'h1);
        tick();
        tick();

        // Asynchronous reset in the middle of the fetch of 0x10.
        #2;
        rst = 1'b0;
        #1;
        checkResetValues("async_rst");
        tick();
        tick();
        rst       = 1'b1;
        respDelay = 1;
        tick();
        checkOutput("rel_req",  {63'h0, imem_req},  64'h1);
        checkOutput("rel_addr", {32'h0, imem_addr}, 64'h0);
        n = 0;
        while (!instr_valid && n < 10) begin
            tick();
            n++;
        end
        checkOutput("rel_valid", {63'h0, instr_valid}, 64'h1);
        memEnable = 1'b0;
        repeat (4) tick();
        checkOutput("rel_err",    {63'h0, fetch_err},   64'h0);
        checkOutput("rel_perf_k", {32'h0, perf_killed}, 64'h0);
        checkOutput("exp_q_left",  64'(expQ.size()),  64'h0);
        checkOutput("addr_q_left", 64'(addrQ.size()), 64'h0);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer for the single-issue RISC-V core.
- Owns the program counter and drives a variable-latency instruction memory with a req/gnt + rvalid handshake, one request in flight at a time.
- Delivers one instruction at a time to decode.
- Honours decode stall and execute-stage redirects (branch/JAL/JALR target), killing stale in-flight fetches and flagging memory timeouts.

Parameters:
PC_WIDTH, 32, width of PC and fetch address
INSTR_WIDTH, 32, instruction word width
RESET_VECTOR, 32'h0000_0000, PC value after reset
TIMEOUT_CYCLES, 16, max cycles waiting for imem_rvalid before error/reissue

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request valid
imem_addr  out  PC_WIDTH  fetch address (word aligned)
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid (one per granted request)
imem_rdata  in  INSTR_WIDTH  read data
stall  in  1  decode cannot accept this cycle
redirect  in  1  control-flow change taken
redirect_target  in  PC_WIDTH  new PC; bits [1:0] forced to 0
instr  out  INSTR_WIDTH  instruction to decode
instr_pc  out  PC_WIDTH  address of instr
instr_valid  out  1  instr/instr_pc valid
fetch_err  out  1  sticky timeout flag
perf_fetched  out  32  delivered-instruction count (see Optional Feature)
perf_killed  out  32  discarded-response count (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_VECTOR, kill=0, wait counter=0.
  - imem_req=0, imem_addr=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, perf counters=0.
- States:
  - IDLE: one cycle after reset release, then REQ. A redirect here loads pc and goes to REQ.
  - REQ:
    - imem_req=1, imem_addr=pc (registered pc, combinational drive).
    - gnt=1 -> WAIT, counter=0.
    - redirect=1 (any gnt): pc<=target.
    - redirect and gnt in the same cycle: kill<=1, go WAIT.
    - redirect without gnt: stay REQ with the new address next cycle.
  - WAIT:
    - imem_req=0; counter increments each cycle.
    - rvalid=1 and (kill=1 or redirect=1): discard data, kill<=0, perf_killed++, -> REQ. If redirect, pc<=target.
    - rvalid=1, clean: instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps modulo 2^PC_WIDTH), perf_fetched++, -> HOLD.
    - redirect with no rvalid: pc<=target, kill<=1, stay WAIT.
    - Counter reaches TIMEOUT_CYCLES-1 with no rvalid: fetch_err<=1 (sticky until reset), kill<=1, -> REQ to reissue the current pc. A late rvalid arriving in REQ is ignored.
  - HOLD:
    - instr_valid=1 held stable.
    - Handoff occurs on the cycle instr_valid=1 and stall=0. Next cycle instr_valid=0, -> REQ.
    - redirect=1: instr_valid<=0 (redirect beats stall), pc<=target, -> REQ.
- Latency:
  - Best case with gnt in first REQ cycle and rvalid one cycle later: REQ, WAIT, HOLD. That is one instruction per 3 cycles.
  - instr_valid rises the cycle after rvalid.
- Redirect always has priority over stall, gnt and rvalid processing. Only redirect_target sampled when redirect=1 is used.
- imem_req never asserted in WAIT, HOLD or IDLE. At most one outstanding request.
- rst asserted mid-transaction: immediate return to reset values. The memory must drop any pending response on reset.

Optional Feature:
- Macro FETCH_SEQ_PERF_EN.
- Defined: perf_fetched and perf_killed are 32-bit free-running counters that wrap at 2^32 and reset to 0.
- Undefined: no counter flops; both ports tied to 0. Ports exist in both builds.

Test Plan:
- Reset release, memory gnt immediate, rvalid 1 cycle later, stall=0: imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses every 3rd cycle with instr_pc 0x0, 0x4, 0x8.
- stall=1 for 5 cycles while instr 0x00500093 at instr_pc 0x4 is valid: instr/instr_pc held for 5 cycles, no imem_req. Next request is to 0x8 after stall drops.
- redirect to 0x100 (target 0x102 also gives 0x100) during WAIT for 0x8: response to 0x8 discarded, perf_killed=1, next imem_addr=0x100, next instr_pc=0x100.
- redirect to 0x40 in HOLD with stall=1: instr_valid drops next cycle, next request address 0x40.
- rvalid withheld for 16 cycles after gnt of 0xC: fetch_err=1 and remains set, request reissued to 0xC. A late rvalid is ignored. Next good response is delivered with instr_pc=0xC.
- rst driven low mid-WAIT without clock edge: outputs immediately at reset values. After release, first imem_addr=RESET_VECTOR. With FETCH_SEQ_PERF_EN undefined, perf ports read 0 throughout.
